// File: rtl/mips_pkg.sv
// Shared widths, constants and types for the instruction fetch path.
package mips_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP    = 32'h0000_0004;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // One buffered instruction together with the address that follows it.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc4;
  } fetch_entry_t;

  // Clear the byte-offset bits of a fetch target.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO with clear and occupancy count. The head word is shown
// combinationally; a push into a full FIFO is accepted when it pops in the
// same cycle.
module inst_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             empty_s;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_s   = (count_r == {(AW+1){1'b0}});
  assign full_s    = (count_r == FULL_CNT);
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);
  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
      rd_ptr_r <= rd_ptr_r + AW'(pop_ok_s);
      count_r  <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Storage write; contents need no reset because the count gates them.
  always_ff @(posedge clk) begin
    if (rst && !clr && push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch unit: owns the fetch PC, keeps up to DEPTH requests
// and buffered instructions in flight, and hands one instruction per cycle
// to IF/ID from a registered head slot. Redirects flush everything and
// discard responses that were already in flight.
module fetch_prefetch_queue
  import mips_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [31:0]      RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              deq_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc4
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] fetch_pc_r;
  logic [CW-1:0]     outstanding_r;
  logic [CW-1:0]     discard_r;
  logic              out_valid_r;
  logic [INST_W-1:0] out_inst_r;
  logic [ADDR_W-1:0] out_pc4_r;

  // Handshakes and credit
  logic              req_fire_s;
  logic [CW:0]       occupancy_s;
  logic              discarding_s;
  logic              enq_s;
  logic              deq_s;

  // Entry queue (holds everything behind the head slot)
  logic              q_push_s;
  logic              q_pop_s;
  fetch_entry_t      q_head_s;
  logic [CW-1:0]     q_count_s;
  logic              q_empty_s;

  // Request-address queue (PC of each accepted, non-stale request)
  logic [ADDR_W-1:0] a_head_s;
  logic [CW-1:0]     a_count_s;
  logic              a_empty_s;

  // Head slot control
  logic              out_load_s;
  logic              out_clear_s;
  logic              out_from_q_s;
  fetch_entry_t      rsp_entry_s;
  fetch_entry_t      out_next_s;

  // Buffered instructions include the head slot; same-cycle dequeue is not credited.
  assign occupancy_s = (CW+1)'(q_count_s) + (CW+1)'(out_valid_r) + (CW+1)'(outstanding_r);

  assign imem_req_valid = rst & ~redirect & (occupancy_s < DEPTH_L);
  assign imem_req_addr  = fetch_pc_r;
  assign req_fire_s     = imem_req_valid & imem_req_ready;

  assign discarding_s = (discard_r != {CW{1'b0}});
  assign a_empty_s    = (a_count_s == {CW{1'b0}});
  assign q_empty_s    = (q_count_s == {CW{1'b0}});
  assign enq_s        = imem_rsp_valid & ~discarding_s & ~redirect & ~a_empty_s;
  assign deq_s        = out_valid_r & deq_ready;

  assign rsp_entry_s.inst = imem_rsp_data;
  assign rsp_entry_s.pc4  = a_head_s + PC_STEP;
  assign out_next_s       = out_from_q_s ? q_head_s : rsp_entry_s;

  assign out_valid = out_valid_r;
  assign out_inst  = out_inst_r;
  assign out_pc4   = out_pc4_r;

  inst_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect),
    .push      (q_push_s),
    .push_data (rsp_entry_s),
    .pop       (q_pop_s),
    .head_data (q_head_s),
    .count     (q_count_s)
  );

  inst_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect),
    .push      (req_fire_s),
    .push_data (fetch_pc_r),
    .pop       (enq_s),
    .head_data (a_head_s),
    .count     (a_count_s)
  );

  // Steer each response into the head slot or the queue, and refill the head on dequeue.
  always_comb begin
    q_push_s     = 1'b0;
    q_pop_s      = 1'b0;
    out_load_s   = 1'b0;
    out_clear_s  = 1'b0;
    out_from_q_s = 1'b0;
    if (redirect) begin
      out_clear_s = 1'b1;
    end else if (out_valid_r) begin
      if (deq_s) begin
        if (!q_empty_s) begin
          out_load_s   = 1'b1;
          out_from_q_s = 1'b1;
          q_pop_s      = 1'b1;
          q_push_s     = enq_s;
        end else if (enq_s) begin
          out_load_s = 1'b1;
        end else begin
          out_clear_s = 1'b1;
        end
      end else begin
        q_push_s = enq_s;
      end
    end else begin
      out_load_s = enq_s;
    end
  end

  // Fetch PC: restart on reset or redirect, otherwise advance on each accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_r <= word_align(redirect_pc);
    end else if (req_fire_s) begin
      fetch_pc_r <= fetch_pc_r + PC_STEP;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // In-flight request count and the number of stale responses still to drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
    end else begin
      outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(imem_rsp_valid);
      if (redirect) begin
        discard_r <= outstanding_r - CW'(imem_rsp_valid);
      end else if (imem_rsp_valid && discarding_s) begin
        discard_r <= discard_r - CW'(1'b1);
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Registered head slot driving IF/ID; shows a nop whenever it is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_inst_r  <= NOP_INST;
      out_pc4_r   <= {ADDR_W{1'b0}};
    end else if (out_clear_s) begin
      out_valid_r <= 1'b0;
      out_inst_r  <= NOP_INST;
      out_pc4_r   <= {ADDR_W{1'b0}};
    end else if (out_load_s) begin
      out_valid_r <= 1'b1;
      out_inst_r  <= out_next_s.inst;
      out_pc4_r   <= out_next_s.pc4;
    end else begin
      out_valid_r <= out_valid_r;
      out_inst_r  <= out_inst_r;
      out_pc4_r   <= out_pc4_r;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue with an in-order, fixed-latency
// instruction memory model. Directed phases push expected {inst, pc4} pairs;
// a separate monitor compares every instruction IF/ID consumes.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        deq_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [63:0] exp_q[$];
  int          n_pass;
  int          n_total;
  int          cyc;
  int          mem_lat;
  int          fires;
  logic        rst_v;
  logic        rdy_toggle;
  logic [31:0] exp_pc;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .deq_ready      (deq_ready),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc4        (out_pc4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // One clock cycle: drive inputs at negedge, play memory, record handshakes.
  task automatic step(input logic dr, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    cyc++;
    deq_ready      = dr;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = rdy_toggle ? ((cyc % 2) == 0) : 1'b1;
    rst            = rst_v;
    if (!rst_v) begin
      pending.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end else if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(pending[0].addr);
      void'(pending.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (rd && rst_v) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      chk("req_blocked_on_redirect", 32'(imem_req_valid), 32'd0);
    end
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      chk("req_addr", imem_req_addr, exp_pc);
      pending.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      exp_pc = exp_pc + 32'd4;
    end
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_v = 1'b0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      if (i >= 1) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc4", out_pc4, 32'h0);
      end
    end
    exp_q.delete();
    exp_pc = RESET_PC;
    fires  = 0;
    rst_v  = 1'b1;
  endtask

  task automatic expect_seq(input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = a + 32'(4 * i);
      exp_q.push_back({inst_of(pc), pc + 32'd4});
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every consumed instruction against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && redirect === 1'b0) begin
        if (out_valid) begin
          if (deq_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_out_pc4", out_pc4, 32'hFFFF_FFFF);
            end else begin
              logic [63:0] e;
              e = exp_q.pop_front();
              chk("out_inst", out_inst, e[63:32]);
              chk("out_pc4", out_pc4, e[31:0]);
            end
          end
        end else begin
          chk("nop_when_invalid", out_inst, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; fires = 0;
    mem_lat = 1; rdy_toggle = 1'b0; exp_pc = RESET_PC; rst_v = 1'b0;
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    deq_ready = 1'b0;

    // Stream from reset: first instruction two cycles after release, then one per cycle.
    do_reset(3);
    expect_seq(32'h0, 8);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("t1_out_valid", 32'(out_valid), (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("t1_consumed", 32'(exp_q.size()), 32'd0);

    // Decode stall: exactly DEPTH requests, then an in-order drain with no gap.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("t2_fires", 32'(fires), 32'd4);
    chk("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
    expect_seq(32'h0, 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("t2_no_gap", 32'(out_valid), 32'd1);
    end
    chk("t2_consumed", 32'(exp_q.size()), 32'd0);

    // 3-cycle memory, redirect with three requests in flight.
    mem_lat = 3;
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    chk("t3_fires_before", 32'(fires), 32'd3);
    step(1'b0, 1'b1, 32'h0000_0040);
    expect_seq(32'h0000_0040, 4);
    drain(60);

    // Redirect on a response cycle, then again one cycle later.
    mem_lat = 2;
    do_reset(2);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0060);
    step(1'b0, 1'b1, 32'h0000_0080);
    expect_seq(32'h0000_0080, 4);
    drain(60);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("t4_full_before", 32'(out_valid), 32'd1);
    fires = 0;
    step(1'b0, 1'b1, 32'h0000_00C0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (i == 0) chk("t4_flushed", 32'(out_valid), 32'd0);
    end
    chk("t4_credit_restored", 32'(fires), 32'd4);
    expect_seq(32'h0000_00C0, 4);
    drain(40);

    // Address wrap with a toggling ready and a misaligned target.
    mem_lat = 1;
    do_reset(2);
    rdy_toggle = 1'b1;
    step(1'b1, 1'b1, 32'hFFFF_FFFB);
    expect_seq(32'hFFFF_FFF8, 4);
    drain(40);
    rdy_toggle = 1'b0;

    // Reset with a full queue, then restart from RESET_PC.
    do_reset(2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("t6_full", 32'(out_valid), 32'd1);
    do_reset(1);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_inst", out_inst, 32'h0);
    chk("t6_out_pc4", out_pc4, 32'h0);
    chk("t6_restart_fires", 32'(fires), 32'd1);
    expect_seq(RESET_PC, 4);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
